// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: opcode encodings, counter width
// and the direction decode.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLEZ = 3'b010;
  localparam logic [2:0] BR_BGTZ = 3'b011;
  localparam logic [2:0] BR_BLTZ = 3'b100;
  localparam logic [2:0] BR_BGEZ = 3'b101;
  localparam logic [2:0] BR_J    = 3'b110;
  localparam logic [2:0] BR_RSVD = 3'b111;

  localparam int unsigned CNT_W = 16;

  // Direction from the zero-compare flags of rs and of rs ^ rt.
  function automatic logic br_taken(input logic [2:0] op,
                                    input logic       gtz,
                                    input logic       eqz,
                                    input logic       ltz,
                                    input logic       rs_eq_rt);
    logic t;
    t = 1'b0;
    case (op)
      BR_BEQ:  t = rs_eq_rt;
      BR_BNE:  t = !rs_eq_rt;
      BR_BLEZ: t = ltz | eqz;
      BR_BGTZ: t = gtz;
      BR_BLTZ: t = ltz;
      BR_BGEZ: t = gtz | eqz;
      BR_J:    t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/compare_to_zero_32.sv
// Signed classification of a 32-bit value against zero.
module compare_to_zero_32 (
  input  logic [31:0] val_i,
  output logic        gtz_o,
  output logic        eqz_o,
  output logic        ltz_o
);

  assign eqz_o = (val_i == 32'h0);
  assign ltz_o = val_i[31];
  assign gtz_o = !val_i[31] && !eqz_o;

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 captures operands and compare flags, S2 holds the
// resolved direction, target and redirect. Also counts delivered mispredicts.
module branch_resolve_unit
  import branch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           br_op,
  input  logic [31:0]          rs_val,
  input  logic [31:0]          rt_val,
  input  logic [31:0]          pc_plus4,
  input  logic [25:0]          imm,
  input  logic                 pred_taken,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 taken,
  output logic [31:0]          target,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     mispredict_count
);

  logic        rs_gt, rs_eq, rs_lt;
  logic        rs_eq_rt;
  logic        unused_xor_gt, unused_xor_lt;
  logic [31:0] rs_xor_rt;

  assign rs_xor_rt = rs_val ^ rt_val;

  compare_to_zero_32 u_cmp_rs (
    .val_i (rs_val),
    .gtz_o (rs_gt),
    .eqz_o (rs_eq),
    .ltz_o (rs_lt)
  );

  // Zero XOR means the operands are equal; only the equal flag matters here.
  compare_to_zero_32 u_cmp_eq (
    .val_i (rs_xor_rt),
    .gtz_o (unused_xor_gt),
    .eqz_o (rs_eq_rt),
    .ltz_o (unused_xor_lt)
  );

  // S1 state
  logic        s1_valid_q;
  logic [2:0]  s1_op_q;
  logic [31:0] s1_pc_q;
  logic [25:0] s1_imm_q;
  logic        s1_pred_q;
  logic        s1_gt_q, s1_eq_q, s1_lt_q, s1_req_q;

  // S2 state
  logic        s2_valid_q;
  logic        s2_taken_q;
  logic [31:0] s2_target_q;
  logic        s2_mispredict_q;
  logic [31:0] s2_redirect_q;
  logic        s2_illegal_q;

  logic [CNT_W-1:0] cnt_q;

  logic s2_load, s1_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_pc_q    <= '0;
      s1_imm_q   <= '0;
      s1_pred_q  <= 1'b0;
      s1_gt_q    <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_lt_q    <= 1'b0;
      s1_req_q   <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (s1_load) begin
        s1_valid_q <= in_valid;
      end
      if (s1_load && in_valid && !flush) begin
        s1_op_q   <= br_op;
        s1_pc_q   <= pc_plus4;
        s1_imm_q  <= imm;
        s1_pred_q <= pred_taken;
        s1_gt_q   <= rs_gt;
        s1_eq_q   <= rs_eq;
        s1_lt_q   <= rs_lt;
        s1_req_q  <= rs_eq_rt;
      end
    end
  end

  logic        taken_d;
  logic [31:0] br_tgt, j_tgt, target_d;

  always_comb begin
    br_tgt   = s1_pc_q + {{14{s1_imm_q[15]}}, s1_imm_q[15:0], 2'b00};
    j_tgt    = {s1_pc_q[31:28], s1_imm_q, 2'b00};
    target_d = (s1_op_q == BR_J) ? j_tgt : br_tgt;
    taken_d  = br_taken(s1_op_q, s1_gt_q, s1_eq_q, s1_lt_q, s1_req_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q      <= 1'b0;
      s2_taken_q      <= 1'b0;
      s2_target_q     <= '0;
      s2_mispredict_q <= 1'b0;
      s2_redirect_q   <= '0;
      s2_illegal_q    <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid_q <= 1'b0;
      end else if (s2_load) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_load && s1_valid_q && !flush) begin
        s2_taken_q      <= taken_d;
        s2_target_q     <= target_d;
        s2_mispredict_q <= taken_d ^ s1_pred_q;
        s2_redirect_q   <= taken_d ? target_d : s1_pc_q;
        s2_illegal_q    <= (s1_op_q == BR_RSVD);
      end
    end
  end

  // Counts on the delivering handshake; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_mispredict_q && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid        = s2_valid_q;
  assign taken            = s2_taken_q;
  assign target           = s2_target_q;
  assign mispredict       = s2_mispredict_q;
  assign redirect_pc      = s2_redirect_q;
  assign illegal_op       = s2_illegal_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [2:0]  br_op;
  logic [31:0] rs_val, rt_val, pc_plus4;
  logic [25:0] imm;
  logic        pred_taken, out_valid, out_ready, taken, mispredict, illegal_op;
  logic [31:0] target, redirect_pc;
  logic [15:0] mispredict_count;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] cnt_exp = 16'h0;

  branch_resolve_unit dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .br_op            (br_op),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .pc_plus4         (pc_plus4),
    .imm              (imm),
    .pred_taken       (pred_taken),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .taken            (taken),
    .target           (target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .illegal_op       (illegal_op),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] pc, input logic [25:0] im, input logic pred);
    br_op      = op;
    rs_val     = rs;
    rt_val     = rt;
    pc_plus4   = pc;
    imm        = im;
    pred_taken = pred;
  endtask

  // One isolated request: issue, check result two edges later, consume it.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] pc, input logic [25:0] im,
                         input logic pred, input logic et, input logic [31:0] etgt,
                         input logic chk_tgt, input logic eill);
    drive(op, rs, rt, pc, im, pred);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " taken"}, 32'(taken), 32'(et));
    if (chk_tgt) chk({tag, " target"}, target, etgt);
    chk({tag, " mispredict"}, 32'(mispredict), 32'(et ^ pred));
    chk({tag, " redirect"}, redirect_pc, et ? etgt : pc);
    chk({tag, " illegal"}, 32'(illegal_op), 32'(eill));
    tick();
    if ((et ^ pred) && cnt_exp != 16'hFFFF) cnt_exp++;
    chk({tag, " count"}, 32'(mispredict_count), 32'(cnt_exp));
    chk({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic sgn_taken(input logic [2:0] op, input logic [31:0] rs);
    case (op)
      3'b010:  return $signed(rs) <= 0;
      3'b011:  return $signed(rs) > 0;
      3'b100:  return $signed(rs) < 0;
      default: return $signed(rs) >= 0;
    endcase
  endfunction

  logic [31:0] sweep_vals [5];
  logic [31:0] exp_q [$];
  logic [31:0] held;
  int sent, popped;
  logic acc, hs;

  initial begin
    sweep_vals[0] = 32'h8000_0000;
    sweep_vals[1] = 32'hFFFF_FFFF;
    sweep_vals[2] = 32'h0000_0000;
    sweep_vals[3] = 32'h0000_0001;
    sweep_vals[4] = 32'h7FFF_FFFF;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst taken", 32'(taken), 32'd0);
    chk("rst mispredict", 32'(mispredict), 32'd0);
    chk("rst illegal", 32'(illegal_op), 32'd0);
    chk("rst target", target, 32'h0);
    chk("rst redirect", redirect_pc, 32'h0);
    chk("rst count", 32'(mispredict_count), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);

    run_one("beq", 3'b000, 32'h1234, 32'h1234, 32'h0040_0010, 26'h0004, 1'b0,
            1'b1, 32'h0040_0020, 1'b1, 1'b0);
    chk("beq count is 1", 32'(mispredict_count), 32'd1);

    for (int o = 2; o <= 5; o++) begin
      for (int v = 0; v < 5; v++) begin
        run_one($sformatf("sweep op%0d rs=%h", o, sweep_vals[v]), 3'(o), sweep_vals[v],
                32'h55, 32'h0, 26'h000FFFF, 1'(v), sgn_taken(3'(o), sweep_vals[v]),
                32'hFFFF_FFFC, 1'b1, 1'b0);
      end
    end

    run_one("beq ne", 3'b000, 32'h5, 32'h6, 32'h0000_1000, 26'h0008, 1'b1,
            1'b0, 32'h0000_1020, 1'b1, 1'b0);
    run_one("bne ne", 3'b001, 32'h5, 32'h6, 32'h0000_1000, 26'h0008, 1'b1,
            1'b1, 32'h0000_1020, 1'b1, 1'b0);
    run_one("bne eq", 3'b001, 32'h9, 32'h9, 32'h0000_1000, 26'h0008, 1'b0,
            1'b0, 32'h0000_1020, 1'b1, 1'b0);
    run_one("jump", 3'b110, 32'h0, 32'h1, 32'hA000_0000, 26'h3FF_FFFF, 1'b1,
            1'b1, 32'hAFFF_FFFC, 1'b1, 1'b0);
    run_one("rsvd", 3'b111, 32'h0, 32'h0, 32'h0000_1000, 26'h0010, 1'b1,
            1'b0, 32'h0, 1'b0, 1'b1);

    // Stream of 8 with a 3-cycle stall in the middle.
    sent = 0; popped = 0;
    for (int cyc = 0; cyc < 40 && popped < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 8);
      drive(3'b000, 32'(sent), 32'(sent), 32'h1000 + 32'(sent) * 16, 26'(sent), 1'b1);
      #1;
      chk($sformatf("stream c%0d in_ready", cyc), 32'(in_ready),
          32'((exp_q.size() < 2) || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("stream c%0d duplicate", cyc), 32'(out_valid), 32'd0);
        end else begin
          chk($sformatf("stream c%0d target", cyc), target, exp_q[0]);
          chk($sformatf("stream c%0d redirect", cyc), redirect_pc, exp_q[0]);
        end
      end
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      tick();
      if (hs && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (acc) begin
        exp_q.push_back(32'h1000 + 32'(sent) * 20);
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("stream delivered", 32'(popped), 32'd8);
    chk("stream count", 32'(mispredict_count), 32'(cnt_exp));

    // Flush with both stages full and a new request pending.
    out_ready = 1'b0;
    drive(3'b000, 32'h7, 32'h7, 32'h2000, 26'h1, 1'b0);
    in_valid = 1'b1;
    tick(); tick();
    chk("flush pre out_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush count", 32'(mispredict_count), 32'(cnt_exp));
    out_ready = 1'b1;
    tick();
    chk("flush dropped a", 32'(out_valid), 32'd0);
    tick();
    chk("flush dropped b", 32'(out_valid), 32'd0);
    chk("flush count after", 32'(mispredict_count), 32'(cnt_exp));

    // Reset during a stall; the concurrent mispredict handshake must not count.
    out_ready = 1'b0;
    drive(3'b000, 32'h3, 32'h3, 32'h3000, 26'h2, 1'b0);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    chk("stall out_valid", 32'(out_valid), 32'd1);
    held = 32'h3008;
    chk("stall target", target, held);
    tick();
    chk("stall hold target", target, held);
    chk("stall hold valid", 32'(out_valid), 32'd1);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    cnt_exp = 16'h0;
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst count", 32'(mispredict_count), 32'd0);
    chk("mid rst target", target, 32'h0);
    tick();
    chk("mid rst drained", 32'(out_valid), 32'd0);

    // Saturation: 65534 then 3 more mispredicts.
    drive(3'b000, 32'h0, 32'h0, 32'h0, 26'h0, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sat pre", 32'(mispredict_count), 32'h0000_FFFE);
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sat hold", 32'(mispredict_count), 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Two-stage pipelined branch resolution unit for the MIPS32 core. It consumes register operands and the branch opcode from decode and produces a taken/not-taken decision, the resolved target and a mispredict redirect for fetch. Sign and zero classification of the operands is done by the existing `compare_to_zero_32` block. The unit sits between the register-read stage and the fetch redirect logic, with valid/ready handshakes on both sides.

## Interface
Parameters:
- none; all widths are fixed at 32-bit data, 26-bit immediate and 3-bit op.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `flush`  in  1  synchronous kill of all in-flight entries.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit accepts the request this cycle.
- `br_op`  in  3  branch opcode; encoding is given under Operation.
- `rs_val`  in  32  rs operand.
- `rt_val`  in  32  rt operand.
- `pc_plus4`  in  32  PC of the branch + 4.
- `imm`  in  26  bits [15:0] hold the branch offset; all 26 bits form the J index.
- `pred_taken`  in  1  prediction made by fetch.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `taken`  out  1  resolved direction.
- `target`  out  32  computed branch or jump target, valid regardless of `taken`.
- `mispredict`  out  1  `taken != pred_taken`.
- `redirect_pc`  out  32  `taken ? target : pc_plus4`.
- `illegal_op`  out  1  `br_op == 3'b111`.
- `mispredict_count`  out  16  saturating count of delivered mispredicts.

## Operation
Opcode encoding and taken condition:
- 000 BEQ: `rs == rt`.
- 001 BNE: `rs != rt`.
- 010 BLEZ: `rs` lesser or equal to zero.
- 011 BGTZ: `rs` greater than zero.
- 100 BLTZ: `rs` lesser than zero.
- 101 BGEZ: `rs` greater than or equal to zero.
- 110 J: always taken.
- 111 reserved: not taken, `illegal_op` = 1.

Compare and target:
- Signed compares use the greater/equal/lesser flags of `compare_to_zero_32` on `rs_val`.
- Equality uses the equal flag of a second `compare_to_zero_32` on `rs_val ^ rt_val`.
- Branch target = `pc_plus4 + {{14{imm[15]}}, imm[15:0], 2'b00}`, 32-bit modular; wrap-around past 0xFFFFFFFC is silently discarded.
- J target = `{pc_plus4[31:28], imm[25:0], 2'b00}`.

Pipeline stages:
- S1 registers the inputs and the compare flags.
- S2 registers `taken`, `target`, `mispredict`, `redirect_pc` and `illegal_op`.
- Each stage holds a valid bit.

Counter:
- `mispredict_count` increments by 1 on each output handshake where `out_valid & out_ready & mispredict`.
- It saturates at 0xFFFF, is cleared only by `reset`, and is unaffected by `flush`.

## Timing
Reset:
- All valid bits are 0, so `out_valid` = 0.
- `taken`, `mispredict` and `illegal_op` are 0; `target` and `redirect_pc` are 0x00000000; `mispredict_count` is 0.
- `in_ready` = 1 in the first cycle after reset deasserts.

Stage advance:
- S2 loads when `!S2.valid || out_ready`.
- S1 loads when `!S1.valid || S2` loads.
- `in_ready` equals the S1 load condition. It is combinational from `out_ready` and has no combinational path from `in_valid`.

Latency and throughput:
- Latency is 2 cycles: accepted at edge N, `out_valid` at edge N+2.
- Throughput is 1 per cycle while `out_ready` = 1.

Backpressure and ordering:
- Under backpressure, output fields hold stable while `out_valid & !out_ready`.
- Results leave in acceptance order.

Flush and reset precedence:
- `flush` clears both valid bits at the edge. An `in_valid` presented in the same cycle is dropped and no output handshake occurs.
- `flush` takes priority over simultaneous advance.
- `reset` mid-stream discards all entries and takes priority over `flush`.
- A simultaneous delivered mispredict and `reset` does not count.

## Structure
- Shared package `branch_pkg`: opcode localparams `BR_BEQ` … `BR_RSVD` and the counter width of 16.
- Two instances of the sub-module `compare_to_zero_32`, one on `rs_val` and one on `rs_val ^ rt_val`.
- Target adders and the counter stay inline.

## Test plan
- BEQ with rs = rt = 0x1234, imm = 0x0004, pc_plus4 = 0x00400010, pred = 0: two cycles later `taken` = 1, `target` = 0x00400020, `mispredict` = 1, `redirect_pc` = 0x00400020, count = 1.
- Sign sweep of BLEZ/BGTZ/BLTZ/BGEZ over rs ∈ {0x80000000, 0xFFFFFFFF, 0, 1, 0x7FFFFFFF}: `taken` matches the signed compare for every pair. Backward offset imm = 0xFFFF from pc_plus4 = 0x00000000 gives `target` 0xFFFFFFFC.
- J with imm = 0x3FFFFFF, pc_plus4 = 0xA0000000: `target` = 0xAFFFFFFC, `taken` = 1. Op 111: `taken` = 0, `illegal_op` = 1.
- Back-to-back stream of 8 requests with `out_ready` low for 3 cycles mid-stream: no loss or duplication, order preserved, outputs stable while stalled, `in_ready` drops after two entries are held.
- `flush` asserted while S1 and S2 are both valid plus a new `in_valid`: next cycle `out_valid` = 0 and no counter change. `reset` during a stall clears `out_valid` and the count.
- 65 537 consecutive mispredicts accepted: `mispredict_count` stops at 0xFFFF.
